// File: rtl/cpu_debug_scan_bridge.sv
// cpu_debug_scan_bridge
//   Bridge between a virtual-JTAG state decoder (strobes already in the clk
//   domain) and the CPU debug logic. It holds one scan register and captures
//   into it from a per-IR-channel source. Each accepted update word becomes a
//   one-hot action with a valid/ready handshake. An update that arrives while
//   an action is still pending is dropped and flagged in a sticky overrun bit.
//   That bit is reported, together with busy, in the top two bits of every
//   capture.
//
// Ports
//   clk, reset          system clock, async active-high reset
//   ir_in, vs_uir       virtual IR value and its update strobe
//   vs_cdr/sdr/udr, tdi capture/shift/update-DR strobes, serial data in
//   tdo                 serial data out (sr[0])
//   cap_data            NUM_CH capture words, DR_WIDTH bits each
//   jdo                 last accepted update word
//   act_valid/act_take  one-hot pending action and its take/no-take flag
//   act_ready           consumer accepts the pending action
//   busy, overrun       action pending; sticky dropped-update flag
module cpu_debug_scan_bridge #(
   parameter int IR_WIDTH = 2,
   parameter int DR_WIDTH = 38,
   parameter int NUM_CH   = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [IR_WIDTH-1:0]        ir_in,
   input  logic                       vs_uir,
   input  logic                       vs_cdr,
   input  logic                       vs_sdr,
   input  logic                       vs_udr,
   input  logic                       tdi,
   output logic                       tdo,
   input  logic [NUM_CH*DR_WIDTH-1:0] cap_data,
   output logic [DR_WIDTH-1:0]        jdo,
   output logic [NUM_CH-1:0]          act_valid,
   output logic                       act_take,
   input  logic                       act_ready,
   output logic                       busy,
   output logic                       overrun
);

   typedef enum logic {IDLE, PEND} state_t;

   localparam logic [IR_WIDTH:0] CH_LIMIT = (IR_WIDTH+1)'(NUM_CH);

   state_t                state, state_d;
   logic [IR_WIDTH-1:0]   ir_q;
   logic [DR_WIDTH-1:0]   sr;
   logic                  uir_win, cdr_win, sdr_win, udr_win;
   logic                  ch_ok, accept, drop, release_act;
   logic [NUM_CH-1:0]     ch_onehot;
   logic [DR_WIDTH-3:0]   cap_word [NUM_CH];
   logic [DR_WIDTH-3:0]   cap_sel;

   // Only the highest-priority strobe in a cycle acts.
   assign uir_win = vs_uir;
   assign cdr_win = vs_cdr & ~vs_uir;
   assign sdr_win = vs_sdr & ~vs_uir & ~vs_cdr;
   assign udr_win = vs_udr & ~vs_uir & ~vs_cdr & ~vs_sdr;

   assign ch_ok = ({1'b0, ir_q} < CH_LIMIT);
   assign tdo   = sr[0];
   assign busy  = (state == PEND);

   generate
      for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
         assign ch_onehot[c] = (ir_q == IR_WIDTH'(c));
         assign cap_word[c]  = cap_data[c*DR_WIDTH +: DR_WIDTH-2];
      end
   endgenerate

   // An out-of-range channel matches no one-hot bit, so its data reads as 0.
   always_comb begin
      cap_sel = '0;
      for (int c = 0; c < NUM_CH; c++)
         if (ch_onehot[c]) cap_sel = cap_word[c];
   end

   always_comb begin
      state_d     = state;
      accept      = 1'b0;
      drop        = 1'b0;
      release_act = 1'b0;
      case (state)
         IDLE: begin
            if (udr_win && ch_ok) begin
               accept  = 1'b1;
               state_d = PEND;
            end
         end
         PEND: begin
            if (act_ready) begin
               // Consumer frees the slot this cycle, so a coincident update
               // takes it directly instead of overrunning.
               if (udr_win && ch_ok) begin
                  accept = 1'b1;
               end else begin
                  release_act = 1'b1;
                  state_d     = IDLE;
               end
            end else if (udr_win && ch_ok) begin
               drop = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ir_q      <= '0;
         sr        <= '0;
         jdo       <= '0;
         act_valid <= '0;
         act_take  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state <= state_d;
         if (uir_win) ir_q <= ir_in;

         if (cdr_win)      sr <= {busy, overrun, cap_sel};
         else if (sdr_win) sr <= {tdi, sr[DR_WIDTH-1:1]};

         // Capture is read-to-clear for overrun.
         if (cdr_win)   overrun <= 1'b0;
         else if (drop) overrun <= 1'b1;

         if (accept) begin
            jdo       <= sr;
            act_valid <= ch_onehot;
            act_take  <= sr[DR_WIDTH-1];
         end else if (release_act) begin
            act_valid <= '0;
         end
      end
   end

endmodule

// File: tb/tb_cpu_debug_scan_bridge.sv
// Directed bench for cpu_debug_scan_bridge. The main instance uses the
// default parameters. A second instance with NUM_CH=3 shares the inputs and
// covers the out-of-range channel case.
module tb_cpu_debug_scan_bridge;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   ir_in;
   logic         vs_uir, vs_cdr, vs_sdr, vs_udr, tdi, act_ready;
   logic [151:0] cap_data;
   logic         tdo, tdo3;
   logic [37:0]  jdo, jdo3;
   logic [3:0]   act_valid;
   logic [2:0]   act_valid3;
   logic         act_take, act_take3, busy, busy3, overrun, overrun3;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   cpu_debug_scan_bridge dut (
      .clk(clk), .reset(reset), .ir_in(ir_in), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
      .vs_sdr(vs_sdr), .vs_udr(vs_udr), .tdi(tdi), .tdo(tdo), .cap_data(cap_data),
      .jdo(jdo), .act_valid(act_valid), .act_take(act_take), .act_ready(act_ready),
      .busy(busy), .overrun(overrun)
   );

   cpu_debug_scan_bridge #(.IR_WIDTH(2), .DR_WIDTH(38), .NUM_CH(3)) dut3 (
      .clk(clk), .reset(reset), .ir_in(ir_in), .vs_uir(vs_uir), .vs_cdr(vs_cdr),
      .vs_sdr(vs_sdr), .vs_udr(vs_udr), .tdi(tdi), .tdo(tdo3), .cap_data(cap_data[113:0]),
      .jdo(jdo3), .act_valid(act_valid3), .act_take(act_take3), .act_ready(act_ready),
      .busy(busy3), .overrun(overrun3)
   );

   // ---------------- stimulus primitives (inputs change after negedge) ----
   task automatic do_uir(input logic [1:0] ir);
      ir_in = ir; vs_uir = 1'b1;
      @(negedge clk);
      vs_uir = 1'b0;
   endtask

   task automatic do_cdr();
      vs_cdr = 1'b1;
      @(negedge clk);
      vs_cdr = 1'b0;
   endtask

   task automatic do_udr(input logic rdy);
      vs_udr = 1'b1; act_ready = rdy;
      @(negedge clk);
      vs_udr = 1'b0; act_ready = 1'b0;
   endtask

   task automatic do_ready();
      act_ready = 1'b1;
      @(negedge clk);
      act_ready = 1'b0;
   endtask

   // Shift din in LSB first while collecting what both instances present on tdo.
   task automatic shift(input logic [37:0] din, output logic [37:0] dout, output logic [37:0] dout3);
      for (int i = 0; i < 38; i++) begin
         dout[i]  = tdo;
         dout3[i] = tdo3;
         tdi      = din[i];
         vs_sdr   = 1'b1;
         @(negedge clk);
         vs_sdr   = 1'b0;
      end
      tdi = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      vecs++; if (tdo !== 1'b0) begin errs++; $display("FAIL reset_tdo got %b exp 0", tdo); end
      vecs++; if (jdo !== 38'h0) begin errs++; $display("FAIL reset_jdo got %h exp 0", jdo); end
      vecs++; if (act_valid !== 4'b0) begin errs++; $display("FAIL reset_act_valid got %b exp 0000", act_valid); end
      vecs++; if (act_take !== 1'b0) begin errs++; $display("FAIL reset_act_take got %b exp 0", act_take); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", busy); end
      vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL reset_overrun got %b exp 0", overrun); end
      vecs++; if (act_valid3 !== 3'b0 || busy3 !== 1'b0) begin errs++;
         $display("FAIL reset_dut3 got valid=%b busy=%b exp 000/0", act_valid3, busy3); end
   endtask

   task automatic test_capture();
      logic [37:0] d, d3;
      do_uir(2'd1);
      do_cdr();
      shift(38'h0, d, d3);
      vecs++; if (d !== 38'h00_1234_5678) begin errs++; $display("FAIL t1_capture got %h exp 0012345678", d); end
      vecs++; if (d3 !== 38'h00_1234_5678) begin errs++; $display("FAIL t1_capture3 got %h exp 0012345678", d3); end
      vecs++; if (tdo !== 1'b0) begin errs++; $display("FAIL t1_tdo_after got %b exp 0", tdo); end
   endtask

   task automatic test_action();
      logic [37:0] d, d3;
      do_uir(2'd2);
      shift(38'h20_0000_00AB, d, d3);
      do_udr(1'b0);
      vecs++; if (act_valid !== 4'b0100) begin errs++; $display("FAIL t2_valid got %b exp 0100", act_valid); end
      vecs++; if (act_take !== 1'b1) begin errs++; $display("FAIL t2_take got %b exp 1", act_take); end
      vecs++; if (jdo !== 38'h20_0000_00AB) begin errs++; $display("FAIL t2_jdo got %h exp 20000000ab", jdo); end
      vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL t2_busy got %b exp 1", busy); end
      repeat (2) @(negedge clk);
      vecs++; if (act_valid !== 4'b0100) begin errs++; $display("FAIL t2_hold got %b exp 0100", act_valid); end
      do_ready();
      vecs++; if (act_valid !== 4'b0000) begin errs++; $display("FAIL t2_release_valid got %b exp 0000", act_valid); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL t2_release_busy got %b exp 0", busy); end
   endtask

   task automatic test_overrun();
      logic [37:0] d, d3;
      do_uir(2'd0);
      shift(38'h00_0000_1111, d, d3);
      do_udr(1'b0);
      vecs++; if (act_valid !== 4'b0001) begin errs++; $display("FAIL t3_valid got %b exp 0001", act_valid); end
      shift(38'h3F_0000_2222, d, d3);
      do_udr(1'b0);
      vecs++; if (overrun !== 1'b1) begin errs++; $display("FAIL t3_overrun got %b exp 1", overrun); end
      vecs++; if (jdo !== 38'h00_0000_1111) begin errs++; $display("FAIL t3_jdo_kept got %h exp 0000001111", jdo); end
      vecs++; if (act_valid !== 4'b0001 || act_take !== 1'b0) begin errs++;
         $display("FAIL t3_action_kept got valid=%b take=%b exp 0001/0", act_valid, act_take); end
      do_cdr();
      vecs++; if (overrun !== 1'b0) begin errs++; $display("FAIL t3_overrun_clear got %b exp 0", overrun); end
      shift(38'h0, d, d3);
      vecs++; if (d !== 38'h30_A5A5_5A5A) begin errs++; $display("FAIL t3_status_capture got %h exp 30a5a55a5a", d); end
      do_ready();
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL t3_release got %b exp 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [37:0] d, d3;
      do_uir(2'd1);
      shift(38'h00_0000_0001, d, d3);
      do_udr(1'b0);
      vecs++; if (act_valid !== 4'b0010) begin errs++; $display("FAIL t4_first got %b exp 0010", act_valid); end
      do_uir(2'd3);
      shift(38'h20_0000_0003, d, d3);
      do_udr(1'b1);
      vecs++; if (act_valid !== 4'b1000) begin errs++; $display("FAIL t4_valid got %b exp 1000", act_valid); end
      vecs++; if (jdo !== 38'h20_0000_0003 || act_take !== 1'b1) begin errs++;
         $display("FAIL t4_word got jdo=%h take=%b exp 2000000003/1", jdo, act_take); end
      vecs++; if (busy !== 1'b1 || overrun !== 1'b0) begin errs++;
         $display("FAIL t4_state got busy=%b ovr=%b exp 1/0", busy, overrun); end
      do_ready();
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL t4_release got %b exp 0", busy); end
   endtask

   task automatic test_priority();
      logic [37:0] d, d3;
      // uir beats cdr: IR moves to 2 and the next capture reads channel 2.
      ir_in = 2'd2; vs_uir = 1'b1; vs_cdr = 1'b1;
      @(negedge clk);
      vs_uir = 1'b0; vs_cdr = 1'b0;
      // sdr beats udr: no action is raised.
      vs_sdr = 1'b1; vs_udr = 1'b1; tdi = 1'b1;
      @(negedge clk);
      vs_sdr = 1'b0; vs_udr = 1'b0; tdi = 1'b0;
      vecs++; if (busy !== 1'b0 || act_valid !== 4'b0) begin errs++;
         $display("FAIL prio_sdr_udr got busy=%b valid=%b exp 0/0000", busy, act_valid); end
      // cdr beats sdr: the register holds the fresh capture, not a shift.
      vs_cdr = 1'b1; vs_sdr = 1'b1; tdi = 1'b1;
      @(negedge clk);
      vs_cdr = 1'b0; vs_sdr = 1'b0; tdi = 1'b0;
      shift(38'h0, d, d3);
      vecs++; if (d !== 38'h00_0BAD_F00D) begin errs++; $display("FAIL prio_capture got %h exp 000badf00d", d); end
   endtask

   task automatic test_bad_channel_and_reset();
      logic [37:0] d, d3;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      do_uir(2'd3);
      do_cdr();
      shift(38'h20_0000_0005, d, d3);
      vecs++; if (d3 !== 38'h0) begin errs++; $display("FAIL t5_capture3 got %h exp 0", d3); end
      vecs++; if (d !== 38'h00_CAFE_0003) begin errs++; $display("FAIL t5_capture got %h exp 00cafe0003", d); end
      do_udr(1'b0);
      do_udr(1'b0);
      vecs++; if (act_valid3 !== 3'b0 || busy3 !== 1'b0 || overrun3 !== 1'b0) begin errs++;
         $display("FAIL t5_ignored3 got valid=%b busy=%b ovr=%b exp 000/0/0", act_valid3, busy3, overrun3); end
      vecs++; if (act_valid !== 4'b1000 || busy !== 1'b1 || overrun !== 1'b1) begin errs++;
         $display("FAIL t5_pend got valid=%b busy=%b ovr=%b exp 1000/1/1", act_valid, busy, overrun); end
      // Reset between clock edges must clear everything without waiting for clk.
      #2 reset = 1'b1;
      #1;
      vecs++; if (act_valid !== 4'b0 || busy !== 1'b0 || act_take !== 1'b0) begin errs++;
         $display("FAIL t5_async_action got valid=%b busy=%b take=%b exp 0000/0/0", act_valid, busy, act_take); end
      vecs++; if (jdo !== 38'h0 || overrun !== 1'b0 || tdo !== 1'b0) begin errs++;
         $display("FAIL t5_async_data got jdo=%h ovr=%b tdo=%b exp 0/0/0", jdo, overrun, tdo); end
      @(negedge clk); reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; ir_in = '0; vs_uir = 0; vs_cdr = 0; vs_sdr = 0; vs_udr = 0;
      tdi = 0; act_ready = 0;
      cap_data = '0;
      cap_data[0*38 +: 38] = 38'h00_A5A5_5A5A;
      cap_data[1*38 +: 38] = 38'h00_1234_5678;
      cap_data[2*38 +: 38] = 38'h00_0BAD_F00D;
      cap_data[3*38 +: 38] = 38'h00_CAFE_0003;
      repeat (2) @(negedge clk);
      test_reset();
      reset = 1'b0;
      @(negedge clk);
      test_capture();
      test_action();
      test_overrun();
      test_back_to_back();
      test_priority();
      test_bad_channel_and_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
